// File: rtl/spi_cmd_arbiter.sv
// spi_cmd_arbiter: shares one SPI master among NREQ instruction sources.
// Round-robin grant into a one-deep instruction slot, master_en sequencing,
// and an in-order owner-tag FIFO that steers returned read data back to
// the requester that issued the read.
//
//   state  | meaning
//   -------+-------------------------------------------------------------
//   IDLE   | master disabled; first eligible instruction starts a burst
//   ACTIVE | master enabled; slot refilled as the master consumes it
//   DRAIN  | master enabled, no loads; waiting for outstanding reads

package spi_pkg;
  parameter int AWIDTH = 8;
  parameter int DWIDTH = 8;
endpackage

module spi_cmd_arbiter #(
  parameter int NREQ   = 4,
  parameter int AWIDTH = spi_pkg::AWIDTH,
  parameter int DWIDTH = spi_pkg::DWIDTH,
  parameter int IWIDTH = DWIDTH + AWIDTH + 5,
  parameter int OSTD   = 4
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic [NREQ-1:0]        req_valid,
  input  logic [NREQ*IWIDTH-1:0] req_instr,
  output logic [NREQ-1:0]        req_ready,
  output logic [DWIDTH-1:0]      req_rdata,
  output logic [NREQ-1:0]        req_rdata_valid,
  input  logic                   master_read,
  output logic                   master_en,
  output logic [IWIDTH-1:0]      driver_data,
  input  logic [DWIDTH-1:0]      master_rdata,
  input  logic                   master_rdata_valid,
  output logic                   tag_err
);

  localparam int TW = (NREQ > 1) ? $clog2(NREQ) : 1;
  localparam int PW = (OSTD > 1) ? $clog2(OSTD) : 1;
  localparam int CW = PW + 1;

  typedef enum logic [1:0] {S_IDLE, S_ACTIVE, S_DRAIN} state_t;

  state_t              state_q, state_d;
  logic                master_en_q, master_en_d;
  logic [IWIDTH-1:0]   driver_data_q, driver_data_d;
  logic                slot_valid_q, slot_valid_d;
  logic [TW-1:0]       rr_q, rr_d;
  logic [TW-1:0]       tag_mem_q [OSTD];
  logic [TW-1:0]       tag_mem_d [OSTD];
  logic [PW-1:0]       wr_ptr_q, wr_ptr_d;
  logic [PW-1:0]       rd_ptr_q, rd_ptr_d;
  logic [CW-1:0]       tag_cnt_q, tag_cnt_d;
  logic [DWIDTH-1:0]   req_rdata_q, req_rdata_d;
  logic [NREQ-1:0]     req_rdata_valid_q, req_rdata_valid_d;
  logic                tag_err_q, tag_err_d;

  logic                pop;
  logic                consume;
  logic [CW-1:0]       cnt_after_pop;
  logic [CW-1:0]       slot_reads;
  logic                read_ok;
  logic [NREQ-1:0]     elig;
  logic                gnt_found;
  logic [TW-1:0]       gnt_idx;
  logic [IWIDTH-1:0]   gnt_instr;
  logic                load_en;
  logic                push;

  // Eligibility and round-robin grant; a pop this cycle already frees a tag.
  always_comb begin
    int idx;
    idx           = 0;
    pop           = master_rdata_valid && (tag_cnt_q != '0);
    consume       = master_read && slot_valid_q && (state_q != S_IDLE);
    cnt_after_pop = tag_cnt_q - CW'(pop);
    slot_reads    = CW'(slot_valid_q && !consume && !driver_data_q[0]);
    read_ok       = (cnt_after_pop + slot_reads) < CW'(OSTD);
    for (int i = 0; i < NREQ; i++) begin
      elig[i] = req_valid[i] && (req_instr[i*IWIDTH] || read_ok);
    end
    gnt_found = 1'b0;
    gnt_idx   = '0;
    for (int k = 1; k <= NREQ; k++) begin
      idx = (int'(rr_q) + k) % NREQ;
      if (!gnt_found && elig[idx]) begin
        gnt_found = 1'b1;
        gnt_idx   = TW'(idx);
      end
    end
    gnt_instr = req_instr[int'(gnt_idx)*IWIDTH +: IWIDTH];
    load_en   = (state_q != S_DRAIN) && (!slot_valid_q || consume) && gnt_found;
    push      = load_en && !gnt_instr[0];
    req_ready = (load_en && !rst) ? (NREQ'(1) << gnt_idx) : '0;
  end

  // Next-state for slot, tag FIFO, read return path and sequencing FSM.
  always_comb begin
    state_d           = state_q;
    master_en_d       = master_en_q;
    driver_data_d     = driver_data_q;
    slot_valid_d      = slot_valid_q;
    rr_d              = rr_q;
    tag_mem_d         = tag_mem_q;
    wr_ptr_d          = wr_ptr_q;
    rd_ptr_d          = rd_ptr_q;
    tag_cnt_d         = tag_cnt_q + CW'(push) - CW'(pop);
    req_rdata_d       = req_rdata_q;
    req_rdata_valid_d = '0;
    tag_err_d         = tag_err_q | (master_rdata_valid && (tag_cnt_q == '0));

    if (consume) slot_valid_d = 1'b0;
    if (load_en) begin
      slot_valid_d  = 1'b1;
      driver_data_d = gnt_instr;
      rr_d          = gnt_idx;
    end

    if (push) begin
      tag_mem_d[wr_ptr_q] = gnt_idx;
      wr_ptr_d            = wr_ptr_q + PW'(1);
    end
    if (pop) begin
      rd_ptr_d          = rd_ptr_q + PW'(1);
      req_rdata_d       = master_rdata;
      req_rdata_valid_d = NREQ'(1) << tag_mem_q[rd_ptr_q];
    end

    case (state_q)
      S_IDLE: begin
        if (load_en) begin
          state_d     = S_ACTIVE;
          master_en_d = 1'b1;
        end
      end
      S_ACTIVE: begin
        if (master_read && !slot_valid_q && !gnt_found) begin
          if (cnt_after_pop == '0) begin
            state_d     = S_IDLE;
            master_en_d = 1'b0;
          end else begin
            state_d = S_DRAIN;
          end
        end
      end
      S_DRAIN: begin
        if (cnt_after_pop == '0) begin
          state_d     = S_IDLE;
          master_en_d = 1'b0;
        end
      end
      default: begin
        state_d     = S_IDLE;
        master_en_d = 1'b0;
      end
    endcase
  end

  // All state and registered outputs; reset drops the slot and every tag.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q           <= S_IDLE;
      master_en_q       <= 1'b0;
      driver_data_q     <= '0;
      slot_valid_q      <= 1'b0;
      rr_q              <= TW'(NREQ - 1);
      for (int i = 0; i < OSTD; i++) tag_mem_q[i] <= '0;
      wr_ptr_q          <= '0;
      rd_ptr_q          <= '0;
      tag_cnt_q         <= '0;
      req_rdata_q       <= '0;
      req_rdata_valid_q <= '0;
      tag_err_q         <= 1'b0;
    end else begin
      state_q           <= state_d;
      master_en_q       <= master_en_d;
      driver_data_q     <= driver_data_d;
      slot_valid_q      <= slot_valid_d;
      rr_q              <= rr_d;
      tag_mem_q         <= tag_mem_d;
      wr_ptr_q          <= wr_ptr_d;
      rd_ptr_q          <= rd_ptr_d;
      tag_cnt_q         <= tag_cnt_d;
      req_rdata_q       <= req_rdata_d;
      req_rdata_valid_q <= req_rdata_valid_d;
      tag_err_q         <= tag_err_d;
    end
  end

  assign master_en       = master_en_q;
  assign driver_data     = driver_data_q;
  assign req_rdata       = req_rdata_q;
  assign req_rdata_valid = req_rdata_valid_q;
  assign tag_err         = tag_err_q;

endmodule

// File: tb/tb_spi_cmd_arbiter.sv
// Directed bench for spi_cmd_arbiter (NREQ=4, 8-bit addr/data, OSTD=4).
module tb_spi_cmd_arbiter;

  localparam int NREQ = 4;
  localparam int IW   = 21;

  logic              clk;
  logic              rst;
  logic [NREQ-1:0]   req_valid;
  logic [NREQ*IW-1:0] req_instr;
  logic [NREQ-1:0]   req_ready;
  logic [7:0]        req_rdata;
  logic [NREQ-1:0]   req_rdata_valid;
  logic              master_read;
  logic              master_en;
  logic [IW-1:0]     driver_data;
  logic [7:0]        master_rdata;
  logic              master_rdata_valid;
  logic              tag_err;

  logic [IW-1:0]     instr [NREQ];
  logic [IW-1:0]     wv [NREQ];

  int n_cmp = 0;
  int n_mis = 0;

  spi_cmd_arbiter #(.NREQ(NREQ), .OSTD(4)) dut (
    .clk(clk), .rst(rst),
    .req_valid(req_valid), .req_instr(req_instr), .req_ready(req_ready),
    .req_rdata(req_rdata), .req_rdata_valid(req_rdata_valid),
    .master_read(master_read), .master_en(master_en), .driver_data(driver_data),
    .master_rdata(master_rdata), .master_rdata_valid(master_rdata_valid),
    .tag_err(tag_err)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  always_comb begin
    for (int i = 0; i < NREQ; i++) req_instr[i*IW +: IW] = instr[i];
  end

  function automatic logic [IW-1:0] mk(input logic [1:0] ss, input logic [7:0] wd,
                                       input logic [7:0] ad, input logic [1:0] sz,
                                       input logic wr);
    return {ss, wd, ad, sz, wr};
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_mis++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk_all_zero(input string pfx);
    chk({pfx, "_en"},     32'(master_en), 0);
    chk({pfx, "_data"},   32'(driver_data), 0);
    chk({pfx, "_ready"},  32'(req_ready), 0);
    chk({pfx, "_rdata"},  32'(req_rdata), 0);
    chk({pfx, "_rvalid"}, 32'(req_rdata_valid), 0);
    chk({pfx, "_tagerr"}, 32'(tag_err), 0);
  endtask

  logic [IW-1:0] w0, r0, r1, r2, r3, w3x;

  initial begin
    w0  = mk(2'b01, 8'hA5, 8'h10, 2'b00, 1'b1);
    r0  = mk(2'b00, 8'h00, 8'h50, 2'b00, 1'b0);
    r1  = mk(2'b00, 8'h00, 8'h41, 2'b00, 1'b0);
    r2  = mk(2'b00, 8'h00, 8'h42, 2'b00, 1'b0);
    r3  = mk(2'b00, 8'h00, 8'h43, 2'b00, 1'b0);
    w3x = mk(2'b10, 8'h77, 8'h33, 2'b01, 1'b1);
    for (int i = 0; i < NREQ; i++) begin
      wv[i]    = mk(2'b00, 8'h20 + 8'(i), 8'h30 + 8'(i), 2'b00, 1'b1);
      instr[i] = '0;
    end
    rst = 1'b1; req_valid = '0; master_read = 1'b0;
    master_rdata = '0; master_rdata_valid = 1'b0;
    #2;
    chk_all_zero("reset");
    tick(); tick();
    rst = 1'b0;

    // single write from req0
    instr[0] = w0; req_valid = 4'b0001; #1;
    chk("t1_ready", 32'(req_ready), 32'h1);
    chk("t1_en_before", 32'(master_en), 0);
    tick();
    req_valid = '0; #1;
    chk("t1_en", 32'(master_en), 1);
    chk("t1_data", 32'(driver_data), 32'(w0));
    master_read = 1'b1; tick(); master_read = 1'b0; #1;
    chk("t1_en_after_consume", 32'(master_en), 1);
    master_read = 1'b1; tick(); master_read = 1'b0; #1;
    chk("t1_idle", 32'(master_en), 0);

    // fresh round-robin pointer
    rst = 1'b1; tick(); rst = 1'b0;

    // all requesters writing, zero-bubble refill
    for (int i = 0; i < NREQ; i++) instr[i] = wv[i];
    req_valid = 4'b1111; #1;
    chk("t2_first_ready", 32'(req_ready), 32'h1);
    tick();
    master_read = 1'b1;
    for (int k = 0; k < 5; k++) begin
      #1;
      chk("t2_data", 32'(driver_data), 32'(wv[k % 4]));
      chk("t2_ready", 32'(req_ready), 32'(1 << ((k + 1) % 4)));
      tick();
    end
    req_valid = '0; #1;
    chk("t2_ready_none", 32'(req_ready), 0);
    tick(); tick();
    master_read = 1'b0; #1;
    chk("t2_idle", 32'(master_en), 0);

    // reads from req2 then req1
    instr[2] = r2; req_valid = 4'b0100; #1;
    chk("t3_ready2", 32'(req_ready), 32'h4);
    tick();
    instr[1] = r1; req_valid = 4'b0010; master_read = 1'b1; #1;
    chk("t3_ready1", 32'(req_ready), 32'h2);
    chk("t3_data2", 32'(driver_data), 32'(r2));
    tick();
    req_valid = '0; #1;
    chk("t3_data1", 32'(driver_data), 32'(r1));
    tick();
    master_read = 1'b0; master_rdata = 8'h3C; master_rdata_valid = 1'b1;
    tick();
    master_rdata = 8'hC3; #1;
    chk("t3_rdata_a", 32'(req_rdata), 32'h3C);
    chk("t3_rvalid_a", 32'(req_rdata_valid), 32'h4);
    tick();
    master_rdata_valid = 1'b0; #1;
    chk("t3_rdata_b", 32'(req_rdata), 32'hC3);
    chk("t3_rvalid_b", 32'(req_rdata_valid), 32'h2);
    tick(); #1;
    chk("t3_rvalid_pulse", 32'(req_rdata_valid), 0);
    master_read = 1'b1; tick(); master_read = 1'b0; #1;
    chk("t3_tags_zero", 32'(master_en), 0);

    // tag FIFO full: reads masked, write bypasses, pop frees a read grant
    instr[0] = r0; req_valid = 4'b0001; #1;
    chk("t4_ready_r0", 32'(req_ready), 32'h1);
    tick();
    master_read = 1'b1;
    for (int k = 0; k < 3; k++) begin
      #1;
      chk("t4_ready_rn", 32'(req_ready), 32'h1);
      tick();
    end
    instr[3] = w3x; req_valid = 4'b1001; #1;
    chk("t4_write_bypass", 32'(req_ready), 32'h8);
    tick();
    req_valid = 4'b0001; master_read = 1'b0; #1;
    chk("t4_data_w", 32'(driver_data), 32'(w3x));
    chk("t4_slot_full", 32'(req_ready), 0);
    master_read = 1'b1; #1;
    chk("t4_read_masked", 32'(req_ready), 0);
    tick();
    master_read = 1'b0; #1;
    chk("t4_masked_empty", 32'(req_ready), 0);
    master_rdata = 8'h11; master_rdata_valid = 1'b1; #1;
    chk("t4_pop_frees", 32'(req_ready), 32'h1);
    tick();
    master_rdata_valid = 1'b0; req_valid = '0; #1;
    chk("t4_rvalid", 32'(req_rdata_valid), 32'h1);
    chk("t4_rdata", 32'(req_rdata), 32'h11);
    chk("t4_data_r0", 32'(driver_data), 32'(r0));

    // drain: empty slot with tags pending
    master_read = 1'b1; tick(); master_read = 1'b0;
    master_rdata = 8'h21; master_rdata_valid = 1'b1; tick();
    master_rdata = 8'h22; #1;
    chk("t5_rdata_21", 32'(req_rdata), 32'h21);
    chk("t5_rvalid_21", 32'(req_rdata_valid), 32'h1);
    tick();
    master_rdata_valid = 1'b0; #1;
    chk("t5_rdata_22", 32'(req_rdata), 32'h22);
    master_read = 1'b1; tick(); master_read = 1'b0;
    instr[1] = wv[1]; req_valid = 4'b0010; #1;
    chk("t5_drain_en", 32'(master_en), 1);
    chk("t5_drain_noload", 32'(req_ready), 0);
    master_rdata = 8'h23; master_rdata_valid = 1'b1; tick(); #1;
    chk("t5_rvalid_23", 32'(req_rdata_valid), 32'h1);
    chk("t5_drain_en2", 32'(master_en), 1);
    chk("t5_drain_noload2", 32'(req_ready), 0);
    master_rdata = 8'h24; tick();
    master_rdata_valid = 1'b0; #1;
    chk("t5_idle", 32'(master_en), 0);
    chk("t5_idle_grant", 32'(req_ready), 32'h2);
    chk("t5_rdata_24", 32'(req_rdata), 32'h24);
    tick();
    req_valid = '0; #1;

    // read return with no tags outstanding
    chk("t5_tagerr_clear", 32'(tag_err), 0);
    master_rdata = 8'h99; master_rdata_valid = 1'b1; tick();
    master_rdata_valid = 1'b0; #1;
    chk("t5_tagerr_set", 32'(tag_err), 1);
    chk("t5_tagerr_novalid", 32'(req_rdata_valid), 0);
    chk("t5_tagerr_drop", 32'(req_rdata), 32'h24);
    tick(); #1;
    chk("t5_tagerr_sticky", 32'(tag_err), 1);

    // reset mid-stream with slot full and two tags outstanding
    instr[2] = r2; req_valid = 4'b0100; master_read = 1'b1; #1;
    chk("t6_ready2", 32'(req_ready), 32'h4);
    tick();
    instr[3] = r3; req_valid = 4'b1000; #1;
    chk("t6_ready3", 32'(req_ready), 32'h8);
    tick();
    req_valid = '0; master_read = 1'b0; #1;
    chk("t6_data_r3", 32'(driver_data), 32'(r3));
    for (int i = 0; i < NREQ; i++) instr[i] = wv[i];
    rst = 1'b1; req_valid = 4'b1111; #1;
    chk_all_zero("t6_async");
    tick();
    rst = 1'b0; #1;
    chk("t6_first_grant", 32'(req_ready), 32'h1);
    tick();
    req_valid = '0; #1;
    chk("t6_en", 32'(master_en), 1);
    chk("t6_data", 32'(driver_data), 32'(wv[0]));
    master_read = 1'b1; tick(); tick();
    master_read = 1'b0; #1;
    chk("t6_tags_cleared", 32'(master_en), 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
    $finish;
  end

endmodule
